// File: rtl/sfp_i2c_ctrl.sv
// SFP management I2C master: one-byte register write or 1..16 byte register read on one of CHANNELS buses.
// Define SFP_CLK_STRETCH_EN to honour slave clock stretching through i_scl.
module sfp_i2c_ctrl #(
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 320
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_wr,
  input  logic [23:0]         cmd_in,
  input  logic [1:0]          cmd_ch,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic                nack_err,
  output logic                busy,
  output logic                cmd_drop,
  output logic [CHANNELS-1:0] scl,
  output logic [CHANNELS-1:0] o_sda,
  output logic [CHANNELS-1:0] upr_drv,
  input  logic [CHANNELS-1:0] i_sda,
  input  logic [CHANNELS-1:0] i_scl,
  output logic [3:0]          dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
    RSTART, ADDR_R, ACK4, RDATA, MACK, STOP
  } state_t;

  localparam logic [9:0] PRE_MAX = 10'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [9:0]  pre_q, pre_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [7:0]  sh_q, sh_d;
  logic [23:0] cmd_q, cmd_d;
  logic [1:0]  ch_q, ch_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        drop_q, drop_d;
  logic        ch_ok, tick, stall, sda_in, scl_in, scl_a, rel_a;

  // Command handshake: cmd_wr is a one-cycle valid; the controller is ready when busy=0.
  // A strobe while busy or to a non-existent channel is discarded and answered with cmd_drop.
  assign ch_ok = (int'(cmd_ch) < CHANNELS);
  assign busy  = (state_q != IDLE);

  always_comb begin
    sda_in = 1'b1;
    scl_in = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == 2'(i)) begin
        sda_in = i_sda[i];
        scl_in = i_scl[i];
      end
    end
  end

`ifdef SFP_CLK_STRETCH_EN
  // A released SCL that still reads low means the slave is stretching the clock.
  assign stall = busy && scl_a && !scl_in;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign stall      = 1'b0;
`endif

  // Bus levels for the active channel, decoded from state and quarter-bit phase.
  always_comb begin
    scl_a = 1'b1;
    rel_a = 1'b1;
    case (state_q)
      IDLE: ;
      START, RSTART: begin
        scl_a = !(state_q == RSTART && phase_q == 2'd0);
        rel_a = !phase_q[1];
      end
      STOP: begin
        scl_a = (phase_q != 2'd0);
        rel_a = phase_q[1];
      end
      default: begin
        scl_a = phase_q[0] ^ phase_q[1];
        if (state_q inside {ADDR_W, REG, WDATA, ADDR_R}) rel_a = sh_q[7];
        else if (state_q == MACK) rel_a = (byte_q == 4'd0);
      end
    endcase
  end

  always_comb begin
    scl     = '1;
    upr_drv = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (busy && ch_q == 2'(i)) begin
        scl[i]     = scl_a;
        upr_drv[i] = rel_a;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    cmd_d      = cmd_q;
    ch_d       = ch_q;
    rd_data_d  = rd_data_q;
    nack_d     = nack_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    drop_d     = cmd_wr && !(state_q == IDLE && ch_ok);
    tick       = busy && !stall && (pre_q == PRE_MAX);

    if (state_q == IDLE) begin
      pre_d   = '0;
      phase_d = '0;
      bit_d   = '0;
      if (cmd_wr && ch_ok) begin
        state_d = START;
        cmd_d   = cmd_in;
        ch_d    = cmd_ch;
        byte_d  = cmd_in[3:0];
        nack_d  = 1'b0;
      end
    end else if (!stall) begin
      pre_d = tick ? 10'd0 : pre_q + 10'd1;
    end

    if (tick) phase_d = phase_q + 2'd1;

    // End of phase 2: SCL is high, sample SDA.
    if (tick && phase_q == 2'd2) begin
      if (state_q == RDATA) begin
        sh_d = {sh_q[6:0], sda_in};
        if (bit_q == 3'd7) begin
          rd_data_d  = {sh_q[6:0], sda_in};
          rd_valid_d = 1'b1;
        end
      end else if (state_q inside {ACK1, ACK2, ACK3, ACK4} && sda_in) begin
        nack_d = 1'b1;
      end
    end

    // End of phase 3: bit slot complete, advance the sequence.
    if (tick && phase_q == 2'd3) begin
      case (state_q)
        START: begin
          state_d = ADDR_W;
          sh_d    = {cmd_q[22:16], 1'b0};
        end
        ADDR_W, REG, WDATA, ADDR_R, RDATA: begin
          bit_d = bit_q + 3'd1;
          if (state_q != RDATA) sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            case (state_q)
              ADDR_W:  state_d = ACK1;
              REG:     state_d = ACK2;
              WDATA:   state_d = ACK3;
              ADDR_R:  state_d = ACK4;
              default: state_d = MACK;
            endcase
          end
        end
        ACK1: begin
          if (nack_q) state_d = STOP;
          else begin
            state_d = REG;
            sh_d    = cmd_q[15:8];
          end
        end
        ACK2: begin
          if (nack_q) state_d = STOP;
          else if (cmd_q[23]) state_d = RSTART;
          else begin
            state_d = WDATA;
            sh_d    = cmd_q[7:0];
          end
        end
        ACK3: state_d = STOP;
        RSTART: begin
          state_d = ADDR_R;
          sh_d    = {cmd_q[22:16], 1'b1};
        end
        ACK4: state_d = nack_q ? STOP : RDATA;
        MACK: begin
          if (byte_q == 4'd0) state_d = STOP;
          else begin
            state_d = RDATA;
            byte_d  = byte_q - 4'd1;
          end
        end
        STOP: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      cmd_q      <= '0;
      ch_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      cmd_q      <= cmd_d;
      ch_q       <= ch_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      drop_q     <= drop_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign nack_err    = nack_q;
  assign cmd_drop    = drop_q;
  assign o_sda       = '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sfp_i2c_ctrl.sv
// Directed bench for sfp_i2c_ctrl: bus-level I2C slave/monitor plus immediate-assertion checks.
`timescale 1ns/1ps
module tb_sfp_i2c_ctrl;
  localparam int CH = 2;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_wr;
  logic [23:0]   cmd_in;
  logic [1:0]    cmd_ch;
  logic [7:0]    rd_data;
  logic          rd_valid, done, nack_err, busy, cmd_drop;
  logic [CH-1:0] scl, o_sda, upr_drv, i_sda, i_scl;
  logic [CH-1:0] hold = '0;
  logic [3:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] rdv_q[$];

  // Slave / monitor state
  int         tch = 0;
  logic       nack_mode = 1'b0;
  logic       slv_drv = 1'b1;
  logic [7:0] rd_src [0:3];
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitn = 0, ri = 0, start_cnt = 0, stop_cnt = 0, sr_at = -1;
  logic       first_byte = 1'b0, pend_rd = 1'b0, rd_act = 1'b0;
  logic [7:0] bsh = '0;
  logic [15:0] ack_bits = '0;
  int         ack_n = 0, other_touch = 0, done_cnt = 0, drop_cnt = 0;
  int         cyc = 0;

  sfp_i2c_ctrl #(.CHANNELS(CH), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_in(cmd_in), .cmd_ch(cmd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .nack_err(nack_err),
    .busy(busy), .cmd_drop(cmd_drop), .scl(scl), .o_sda(o_sda), .upr_drv(upr_drv),
    .i_sda(i_sda), .i_scl(i_scl), .dbg_state_o(dbg_state)
  );

  // Clock / reset-independent plumbing
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i_scl = scl & ~hold;

  always_comb begin
    i_sda = '1;
    for (int c = 0; c < CH; c++)
      i_sda[c] = (upr_drv[c] ? 1'b1 : o_sda[c]) & ((c == tch) ? slv_drv : 1'b1);
  end

  // Bus monitor and slave: samples on SCL rise, drives on SCL fall.
  always @(negedge clk) begin : mon
    logic cs, cd;
    cs = scl[tch];
    cd = i_sda[tch];
    if (prev_scl && cs && prev_sda && !cd) begin
      start_cnt++;
      sr_at      = obs_q.size();
      bitn       = 0;
      first_byte = 1'b1;
      pend_rd    = 1'b0;
      rd_act     = 1'b0;
    end else if (prev_scl && cs && !prev_sda && cd) begin
      stop_cnt++;
    end else if (!prev_scl && cs) begin
      if (bitn < 8) begin
        bsh = {bsh[6:0], cd};
        bitn++;
        if (bitn == 8) begin
          obs_q.push_back(bsh);
          if (first_byte && bsh[0]) pend_rd = 1'b1;
          first_byte = 1'b0;
        end
      end else begin
        ack_bits = {ack_bits[14:0], cd};
        ack_n++;
        bitn = 0;
        if (pend_rd) begin
          rd_act  = 1'b1;
          pend_rd = 1'b0;
          ri      = 0;
        end else if (rd_act) begin
          if (cd) rd_act = 1'b0;
          else ri++;
        end
      end
    end else if (prev_scl && !cs) begin
      if (rd_act) slv_drv = (bitn < 8) ? rd_src[ri][7-bitn] : 1'b1;
      else        slv_drv = (bitn == 8) ? nack_mode : 1'b1;
    end
    prev_scl = cs;
    prev_sda = cd;
    for (int c = 0; c < CH; c++)
      if (c != tch && (!scl[c] || !upr_drv[c])) other_touch++;
    if (rd_valid) rdv_q.push_back(rd_data);
    if (done) done_cnt++;
    if (cmd_drop) drop_cnt++;
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, " nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, " byte"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clear();
    obs_q.delete(); exp_q.delete(); rdv_q.delete();
    ack_bits = '0; ack_n = 0; start_cnt = 0; stop_cnt = 0; sr_at = -1;
    done_cnt = 0; drop_cnt = 0; other_touch = 0;
  endtask

  // Driver tasks
  task automatic send(input logic [23:0] c, input logic [1:0] ch);
    cmd_in = c;
    cmd_ch = ch;
    cmd_wr = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st);
    int n = 0;
    while (dbg_state != st && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " state"}, 32'(dbg_state), 32'(st));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_src[0] = 8'h11; rd_src[1] = 8'h22; rd_src[2] = 8'h33; rd_src[3] = 8'h44;
    rst = 1'b1; cmd_wr = 1'b0; cmd_in = '0; cmd_ch = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst scl",      32'(scl),      32'h3);
    check("rst upr_drv",  32'(upr_drv),  32'h3);
    check("rst o_sda",    32'(o_sda),    32'h0);
    check("rst busy",     32'(busy),     32'h0);
    check("rst done",     32'(done),     32'h0);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst cmd_drop", 32'(cmd_drop), 32'h0);
    check("rst nack_err", 32'(nack_err), 32'h0);
    check("rst rd_data",  32'(rd_data),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write 0x5A to reg 0x0A of device 0x50 on ch0
    clear(); tch = 0; nack_mode = 1'b0;
    send(24'h500A5A, 2'd0);
    check("wr busy", 32'(busy), 32'h1);
    wait_idle("wr");
    exp_q.push_back(8'hA0); exp_q.push_back(8'h0A); exp_q.push_back(8'h5A);
    cmp_bytes("wr");
    check("wr ack n",    32'(ack_n),       32'd3);
    check("wr ack bits", 32'(ack_bits),    32'h0);
    check("wr done",     32'(done_cnt),    32'd1);
    check("wr nack",     32'(nack_err),    32'h0);
    check("wr starts",   32'(start_cnt),   32'd1);
    check("wr stops",    32'(stop_cnt),    32'd1);
    check("wr ch1 idle", 32'(other_touch), 32'd0);

    // Read 4 bytes from reg 0x60 of device 0x50 on ch1
    clear(); tch = 1;
    send(24'hD06003, 2'd1);
    wait_idle("rd");
    exp_q.push_back(8'hA0); exp_q.push_back(8'h60); exp_q.push_back(8'hA1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    cmp_bytes("rd bus");
    check("rd ack n",    32'(ack_n),       32'd7);
    check("rd ack bits", 32'(ack_bits),    32'h0001);
    check("rd starts",   32'(start_cnt),   32'd2);
    check("rd sr pos",   32'(sr_at),       32'd2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    obs_q = rdv_q;
    cmp_bytes("rd valid");
    check("rd data",     32'(rd_data),     32'h44);
    check("rd done",     32'(done_cnt),    32'd1);
    check("rd nack",     32'(nack_err),    32'h0);
    check("rd ch0 idle", 32'(other_touch), 32'd0);

    // Absent device: address NACK, then STOP
    clear(); tch = 0; nack_mode = 1'b1;
    send(24'h500A5A, 2'd0);
    wait_idle("nak");
    exp_q.push_back(8'hA0);
    cmp_bytes("nak");
    check("nak ack n",  32'(ack_n),    32'd1);
    check("nak ack",    32'(ack_bits), 32'h1);
    check("nak flag",   32'(nack_err), 32'h1);
    check("nak done",   32'(done_cnt), 32'd1);
    check("nak stops",  32'(stop_cnt), 32'd1);
    nack_mode = 1'b0;

    // Dropped commands: while busy, and to channel 3
    clear();
    send(24'h5A33C3, 2'd0);
    check("drp nack cleared", 32'(nack_err), 32'h0);
    repeat (20) @(negedge clk);
    send(24'h123456, 2'd0);
    check("drp busy pulse", 32'(cmd_drop), 32'h1);
    check("drp still busy", 32'(busy),     32'h1);
    @(negedge clk);
    check("drp one cycle",  32'(cmd_drop), 32'h0);
    wait_idle("drp");
    exp_q.push_back(8'hB4); exp_q.push_back(8'h33); exp_q.push_back(8'hC3);
    cmp_bytes("drp");
    check("drp done",   32'(done_cnt), 32'd1);
    send(24'h500A5A, 2'd3);
    check("drp ch3 pulse", 32'(cmd_drop), 32'h1);
    check("drp ch3 busy",  32'(busy),     32'h0);
    @(negedge clk);
    check("drp count",  32'(drop_cnt), 32'd2);

    // Reset in the middle of REG, then a normal write
    clear();
    send(24'h500A5A, 2'd0);
    wait_state("mid", 4'd4);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid scl",     32'(scl),       32'h3);
    check("mid upr_drv", 32'(upr_drv),   32'h3);
    check("mid busy",    32'(busy),      32'h0);
    check("mid state",   32'(dbg_state), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear();
    send(24'h3C10FF, 2'd0);
    wait_idle("post");
    exp_q.push_back(8'h78); exp_q.push_back(8'h10); exp_q.push_back(8'hFF);
    cmp_bytes("post");
    check("post starts", 32'(start_cnt), 32'd1);
    check("post acks",   32'(ack_bits),  32'h0);
    check("post done",   32'(done_cnt),  32'd1);

`ifdef SFP_CLK_STRETCH_EN
    // Slave stretches SCL for 50 cycles in ACK2
    begin
      int t0, n;
      clear();
      send(24'h500A5A, 2'd0);
      wait_state("str", 4'd5);
      t0 = cyc;
      hold[0] = 1'b1;
      n = 0;
      while (!scl[0] && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (50) @(negedge clk);
      hold[0] = 1'b0;
      n = 0;
      while (dbg_state == 4'd5 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("str ack2 len", 32'(cyc - t0), 32'd66);
      wait_idle("str");
      exp_q.push_back(8'hA0); exp_q.push_back(8'h0A); exp_q.push_back(8'h5A);
      cmp_bytes("str");
      check("str done", 32'(done_cnt), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfp_i2c_ctrl.md
SFP_I2C_CTRL -- requirements
Module: sfp_i2c_ctrl

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent SFP I2C buses (1..4).
REQ-002 Parameter PRESCALE, default 320, clk cycles per quarter SCL period (125 MHz/4/320 = 97.6 kHz); legal range 4..1023.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_wr  in  1  one-cycle command strobe.
REQ-006 cmd_in  in  24  [23]=1 read/0 write; [22:16] 7-bit device address; [15:8] register address; [7:0] write data, or for reads [3:0]=byte count-1.
REQ-007 cmd_ch  in  2  target channel, sampled with cmd_wr.
REQ-008 rd_data  out  8  last byte read.
REQ-009 rd_valid  out  1  one-cycle pulse per read byte.
REQ-010 done  out  1  one-cycle pulse at end of transaction.
REQ-011 nack_err  out  1  sticky slave-NACK flag; cleared by next accepted command.
REQ-012 busy  out  1  transaction in progress.
REQ-013 cmd_drop  out  1  one-cycle pulse when cmd_wr ignored.
REQ-014 scl  out  CHANNELS  SCL per channel, high when idle.
REQ-015 o_sda  out  CHANNELS  SDA drive value, tied low.
REQ-016 upr_drv  out  CHANNELS  SDA tristate control, 1 = released, 0 = drive o_sda.
REQ-017 i_sda  in  CHANNELS  SDA sense per channel.
REQ-018 i_scl  in  CHANNELS  SCL sense per channel; used only with SFP_CLK_STRETCH_EN.

Function
REQ-019 Command accepted when cmd_wr=1 and busy=0; busy asserts the next cycle; cmd_in and cmd_ch are latched.
REQ-020 cmd_wr while busy=1, or with cmd_ch>=CHANNELS, is ignored and pulses cmd_drop the next cycle.
REQ-021 Only the latched channel toggles; all other channels hold scl=1, upr_drv=1.
REQ-022 Bit timing is four phases of PRESCALE cycles each: SDA changes in phase 0 with SCL low; SCL rises at phase 1; SDA is sampled at the end of phase 2; SCL falls at phase 3.
REQ-023 States: IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3, RSTART, ADDR_R, ACK4, RDATA, MACK, STOP.
REQ-024 Write sequence: START, ADDR_W (addr,0), ACK1, REG, ACK2, WDATA, ACK3, STOP, IDLE.
REQ-025 Read sequence: START, ADDR_W, ACK1, REG, ACK2, RSTART, ADDR_R (addr,1), ACK4, then (cmd_in[3:0]+1) x (RDATA, MACK), STOP, IDLE.
REQ-026 Bytes are sent and received MSB first.
REQ-027 MACK drives ACK (SDA low) after every byte except the last, which gets NACK (released).
REQ-028 rd_data updates and rd_valid pulses on the cycle the eighth bit of each byte is sampled.
REQ-029 i_sda=1 in any ACK state sets nack_err and goes directly to STOP; no further bytes are sent.
REQ-030 STOP: SDA low, SCL high, then SDA released; done pulses on the cycle IDLE is re-entered; busy drops the same cycle.
REQ-031 START and RSTART: SDA falls while SCL is high, held for two phases.
REQ-032 Prescale counter is 10 bits and wraps to 0 at PRESCALE-1.
REQ-033 The byte counter is 4 bits; a read of 16 bytes is legal.

Reset
REQ-034 rst asynchronously forces IDLE: scl=all 1, upr_drv=all 1, o_sda=0, busy=0, done=0, rd_valid=0, cmd_drop=0, nack_err=0, rd_data=0.
REQ-035 rst mid-transaction releases the bus immediately and issues no STOP; the first command after reset starts with START.

Configuration
REQ-036 Macro SFP_CLK_STRETCH_EN, when defined: after releasing SCL, the prescale counter holds while i_scl of the active channel reads 0, so slave clock stretching is honoured.
REQ-037 SFP_CLK_STRETCH_EN undefined: i_scl is ignored and timing is strictly PRESCALE-based.

Verification
REQ-038 PRESCALE=4; write cmd_in=0x50_0A_5A, ch0; slave ACKs -> SDA carries A0,0A,5A; done after STOP; nack_err=0; ch1 stays idle.
REQ-039 Read cmd_in=0xD0_60_03, ch1; slave returns 11,22,33,44 -> four rd_valid pulses with those values; master ACKs x3, then NACKs; Sr appears before A1.
REQ-040 Write to an absent device (i_sda stuck 1) -> nack_err=1 after the address byte, STOP, done; no REG byte on the bus.
REQ-041 cmd_wr during busy, and cmd_ch=3 with CHANNELS=2 -> cmd_drop pulse; in-flight transaction unaffected.
REQ-042 rst asserted in the middle of REG -> next cycle all scl=1, upr_drv=1, busy=0; the next command completes normally.
REQ-043 With SFP_CLK_STRETCH_EN, slave holds i_scl low 50 cycles at ACK2 -> SCL high phase is delayed 50 cycles; the data returned is unchanged.
